// File: rtl/branch_predictor_unit.sv
// Fetch-side branch predictor: direct-mapped BTB, GAg/gshare PHT, checkpointed RAS.
// Lookup is combinational on the IF PC; training and history repair come from EX.
module branch_predictor_unit #(
  parameter int BTB_ENTRIES = 16,
  parameter int GHR_LEN     = 4,
  parameter int MODE        = 1,
  parameter int RAS_DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         if_valid_i,
  input  logic [31:0]                  if_pc_i,
  output logic                         pred_hit_o,
  output logic                         pred_taken_o,
  output logic [31:0]                  pred_target_o,
  output logic [GHR_LEN-1:0]           pred_ghr_o,
  output logic [2*$clog2(RAS_DEPTH):0] pred_ras_o,
  input  logic                         ex_upd_i,
  input  logic [31:0]                  ex_pc_i,
  input  logic [1:0]                   ex_type_i,
  input  logic                         ex_call_i,
  input  logic                         ex_taken_i,
  input  logic [31:0]                  ex_target_i,
  input  logic [GHR_LEN-1:0]           ex_ghr_i,
  input  logic [2*$clog2(RAS_DEPTH):0] ex_ras_i,
  input  logic                         ex_mispredict_i
);

  localparam int IDX   = $clog2(BTB_ENTRIES);
  localparam int TAG_W = 30 - IDX;
  localparam int PHT_N = 1 << GHR_LEN;
  localparam int RAS_W = $clog2(RAS_DEPTH);

  localparam logic [1:0]       T_COND   = 2'b00;
  localparam logic [1:0]       T_RET    = 2'b11;
  localparam logic [RAS_W-1:0] PTR_ONE  = 1;
  localparam logic [RAS_W:0]   CNT_ONE  = 1;
  localparam logic [RAS_W:0]   CNT_FULL = (RAS_W+1)'(RAS_DEPTH);

  function automatic logic [GHR_LEN-1:0] pht_index(input logic [GHR_LEN-1:0] ghr,
                                                   input logic [31:0]        pc);
    if (MODE != 0) return ghr ^ pc[GHR_LEN+1:2];
    return ghr;
  endfunction

  function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic up);
    if (up) return (ctr == 2'b11) ? ctr : ctr + 2'b01;
    return (ctr == 2'b00) ? ctr : ctr - 2'b01;
  endfunction

  // Control state (reset) and storage arrays (contents left unreset).
  logic [BTB_ENTRIES-1:0] btb_valid_q, btb_valid_d;
  logic [TAG_W-1:0]       btb_tag_q  [BTB_ENTRIES];
  logic [31:0]            btb_tgt_q  [BTB_ENTRIES];
  logic [1:0]             btb_type_q [BTB_ENTRIES];
  logic [BTB_ENTRIES-1:0] btb_call_q;
  logic [1:0]             pht_q [PHT_N];
  logic [1:0]             pht_d [PHT_N];
  logic [GHR_LEN-1:0]     ghr_q, ghr_d;
  logic [RAS_W-1:0]       ras_ptr_q, ras_ptr_d;
  logic [RAS_W:0]         ras_cnt_q, ras_cnt_d;
  logic [31:0]            ras_mem_q [RAS_DEPTH];

  logic [IDX-1:0]     l_idx, w_idx;
  logic [TAG_W-1:0]   l_tag;
  logic               l_hit, l_call;
  logic [1:0]         l_type, l_ctr;
  logic [31:0]        l_tgt, l_pc4, ras_top;
  logic [GHR_LEN-1:0] t_idx;
  logic               btb_we, recover;

  logic               op_push, op_pop, ras_we;
  logic [RAS_W:0]     op_cnt;
  logic [RAS_W-1:0]   op_ptr, ras_waddr;
  logic [31:0]        op_val, ras_wdata;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc_i[1:0], ex_pc_i[1:0]};

  assign l_idx   = if_pc_i[IDX+1:2];
  assign l_tag   = if_pc_i[31:IDX+2];
  assign l_hit   = btb_valid_q[l_idx] && (btb_tag_q[l_idx] == l_tag);
  assign l_type  = btb_type_q[l_idx];
  assign l_call  = btb_call_q[l_idx];
  assign l_tgt   = btb_tgt_q[l_idx];
  assign l_pc4   = if_pc_i + 32'd4;
  assign l_ctr   = pht_q[pht_index(ghr_q, if_pc_i)];
  assign ras_top = ras_mem_q[ras_ptr_q - PTR_ONE];

  assign w_idx   = ex_pc_i[IDX+1:2];
  assign t_idx   = pht_index(ex_ghr_i, ex_pc_i);
  assign btb_we  = ex_upd_i & ex_taken_i;
  assign recover = ex_upd_i & ex_mispredict_i;

  assign pred_hit_o = l_hit;
  assign pred_ghr_o = ghr_q;
  assign pred_ras_o = {ras_cnt_q, ras_ptr_q};

  always_comb begin
    pred_taken_o  = 1'b0;
    pred_target_o = l_pc4;
    if (l_hit) begin
      case (l_type)
        T_COND: begin
          pred_taken_o = l_ctr[1];
          if (l_ctr[1]) pred_target_o = l_tgt;
        end
        T_RET: begin
          pred_taken_o  = 1'b1;
          pred_target_o = (ras_cnt_q != '0) ? ras_top : l_tgt;
        end
        default: begin
          pred_taken_o  = 1'b1;
          pred_target_o = l_tgt;
        end
      endcase
    end
  end

  always_comb begin
    pht_d = pht_q;
    if (ex_upd_i && ex_type_i == T_COND)
      pht_d[t_idx] = ctr_update(pht_q[t_idx], ex_taken_i);
    btb_valid_d = btb_valid_q;
    if (btb_we) btb_valid_d[w_idx] = 1'b1;
  end

  // Recovery restores the EX checkpoint and replays that instruction's own RAS effect;
  // otherwise a fetched hit updates history speculatively.
  always_comb begin
    ghr_d   = ghr_q;
    op_cnt  = ras_cnt_q;
    op_ptr  = ras_ptr_q;
    op_push = 1'b0;
    op_pop  = 1'b0;
    op_val  = l_pc4;
    if (recover) begin
      ghr_d   = (ex_type_i == T_COND) ? {ex_ghr_i[GHR_LEN-2:0], ex_taken_i} : ex_ghr_i;
      op_cnt  = ex_ras_i[2*RAS_W:RAS_W];
      op_ptr  = ex_ras_i[RAS_W-1:0];
      op_push = ex_call_i;
      op_pop  = (ex_type_i == T_RET);
      op_val  = ex_pc_i + 32'd4;
    end else if (if_valid_i && l_hit) begin
      if (l_type == T_COND) ghr_d = {ghr_q[GHR_LEN-2:0], pred_taken_o};
      op_push = l_call;
      op_pop  = (l_type == T_RET);
    end

    ras_cnt_d = op_cnt;
    ras_ptr_d = op_ptr;
    ras_we    = 1'b0;
    ras_waddr = op_ptr;
    ras_wdata = op_val;
    if (op_push && op_pop && op_cnt != '0) begin
      ras_we    = 1'b1;
      ras_waddr = op_ptr - PTR_ONE;
    end else if (op_push) begin
      ras_we    = 1'b1;
      ras_ptr_d = op_ptr + PTR_ONE;
      if (op_cnt != CNT_FULL) ras_cnt_d = op_cnt + CNT_ONE;
    end else if (op_pop && op_cnt != '0) begin
      ras_ptr_d = op_ptr - PTR_ONE;
      ras_cnt_d = op_cnt - CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btb_valid_q <= '0;
      ghr_q       <= '0;
      ras_ptr_q   <= '0;
      ras_cnt_q   <= '0;
      for (int i = 0; i < PHT_N; i++) pht_q[i] <= 2'b01;
    end else begin
      btb_valid_q <= btb_valid_d;
      ghr_q       <= ghr_d;
      ras_ptr_q   <= ras_ptr_d;
      ras_cnt_q   <= ras_cnt_d;
      pht_q       <= pht_d;
    end
  end

  always_ff @(posedge clk) begin
    if (btb_we) begin
      btb_tag_q[w_idx]  <= ex_pc_i[31:IDX+2];
      btb_tgt_q[w_idx]  <= ex_target_i;
      btb_type_q[w_idx] <= ex_type_i;
      btb_call_q[w_idx] <= ex_call_i;
    end
    if (ras_we) ras_mem_q[ras_waddr] <= ras_wdata;
  end

endmodule
